// File: rtl/snake_input_ctrl_if.sv
// Handshake bundle between the snake input conditioner and its parent:
// raw buttons and game strobes in, conditioned direction/start out.
interface snake_input_ctrl_if;
  logic [3:0] btn_raw;
  logic       start_raw;
  logic       tick;
  logic       game_active;
  logic [3:0] movement;
  logic       start_pulse;
  logic [1:0] queue_count;

  modport master (
    output btn_raw, start_raw, tick, game_active,
    input  movement, start_pulse, queue_count
  );

  modport slave (
    input  btn_raw, start_raw, tick, game_active,
    output movement, start_pulse, queue_count
  );
endinterface

// File: rtl/snake_input_ctrl.sv
// Button conditioner for the snake move stage: sync, debounce, edge-detect, 2-deep turn queue.
// Define REVERSE_FILTER_EN to reject presses opposite to the current reference direction.
module snake_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned CNT_W           = 15
) (
  input  logic                clk,
  input  logic                reset,
  snake_input_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit 4 is start, bits 3:0 are UP/DOWN/LEFT/RIGHT.
  logic [4:0]            sync1_q, sync1_d;
  logic [4:0]            sync2_q, sync2_d;
  logic [4:0]            stable_q, stable_d;
  logic [4:0]            stable_prev_q, stable_prev_d;
  logic [4:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                  start_pulse_q, start_pulse_d;
  logic [3:0]            movement_q, movement_d;
  logic [3:0]            q0_q, q0_d;
  logic [3:0]            q1_q, q1_d;
  logic [1:0]            qcnt_q, qcnt_d;

  logic [4:0] press;
  logic [3:0] dir;
  logic [3:0] ref_dir;
  logic       accept;
  logic       pop;
  logic [1:0] cnt_after;

`ifdef REVERSE_FILTER_EN
  function automatic logic [3:0] opposite(input logic [3:0] d);
    return {d[2], d[3], d[0], d[1]};
  endfunction
`endif

  always_comb begin
    sync1_d       = {bus.start_raw, bus.btn_raw};
    sync2_d       = sync1_q;
    stable_d      = stable_q;
    cnt_d         = cnt_q;
    stable_prev_d = stable_q;

    for (int unsigned i = 0; i < 5; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end

    press         = stable_q & ~stable_prev_q;
    start_pulse_d = press[4];

    if      (press[0]) dir = 4'b0001;
    else if (press[1]) dir = 4'b0010;
    else if (press[2]) dir = 4'b0100;
    else if (press[3]) dir = 4'b1000;
    else               dir = '0;

    // Compare against the newest pending turn so rapid taps chain correctly.
    if (qcnt_q == 2'd2)      ref_dir = q1_q;
    else if (qcnt_q == 2'd1) ref_dir = q0_q;
    else                     ref_dir = movement_q;

`ifdef REVERSE_FILTER_EN
    accept = (dir != '0) && (dir != ref_dir) && (dir != opposite(ref_dir));
`else
    accept = (dir != '0) && (dir != ref_dir);
`endif

    pop        = bus.tick && (qcnt_q != 2'd0);
    cnt_after  = qcnt_q - {1'b0, pop};
    movement_d = movement_q;
    q0_d       = q0_q;
    q1_d       = q1_q;
    qcnt_d     = qcnt_q;

    if (!bus.game_active) begin
      movement_d = '0;
      q0_d       = '0;
      q1_d       = '0;
      qcnt_d     = '0;
    end else begin
      if (pop) begin
        movement_d = q0_q;
        q0_d       = q1_q;
      end
      // Space is judged after this cycle's pop, so a full queue can still take a turn on tick.
      if (accept && cnt_after != 2'd2) begin
        if (cnt_after == 2'd0) q0_d = dir;
        else                   q1_d = dir;
        qcnt_d = cnt_after + 2'd1;
      end else begin
        qcnt_d = cnt_after;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      cnt_q         <= '0;
      start_pulse_q <= 1'b0;
      movement_q    <= '0;
      q0_q          <= '0;
      q1_q          <= '0;
      qcnt_q        <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      cnt_q         <= cnt_d;
      start_pulse_q <= start_pulse_d;
      movement_q    <= movement_d;
      q0_q          <= q0_d;
      q1_q          <= q1_d;
      qcnt_q        <= qcnt_d;
    end
  end

  assign bus.movement    = movement_q;
  assign bus.start_pulse = start_pulse_q;
  assign bus.queue_count = qcnt_q;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Self-checking bench for snake_input_ctrl: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized buttons/ticks/resets.
module tb_snake_input_ctrl;
  localparam int D = 4;
`ifdef REVERSE_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  snake_input_ctrl_if bus();

  snake_input_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: raw sample history, stable levels, a real queue of turns.
  logic [4:0] hist [0:D];
  logic [4:0] m_stable, m_prev;
  logic [3:0] m_mov;
  logic       m_start;
  logic [3:0] m_q [$];

  function automatic logic [3:0] opp(input logic [3:0] d);
    case (d)
      4'b0001: return 4'b0010;
      4'b0010: return 4'b0001;
      4'b0100: return 4'b1000;
      4'b1000: return 4'b0100;
      default: return 4'b0000;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= D; i++) hist[i] = '0;
      m_stable = '0;
      m_prev   = '0;
      m_mov    = '0;
      m_start  = 1'b0;
      m_q.delete();
    end else begin
      logic [4:0] ev;
      logic [3:0] dir, refd;
      bit ok, all_diff;
      ev      = m_stable & ~m_prev;
      m_start = ev[4];
      dir     = '0;
      for (int b = 3; b >= 0; b--) if (ev[b]) dir = 4'(1 << b);
      if (!bus.game_active) begin
        m_q.delete();
        m_mov = '0;
      end else begin
        refd = (m_q.size() > 0) ? m_q[$] : m_mov;
        ok   = (dir != 0) && (dir != refd) && !(FILT && dir == opp(refd));
        if (bus.tick && m_q.size() > 0) m_mov = m_q.pop_front();
        if (ok && m_q.size() < 2) m_q.push_back(dir);
      end
      m_prev = m_stable;
      // Level flips once the D samples that reached the debouncer all disagree with it.
      for (int b = 0; b < 5; b++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= D; k++) if (hist[k][b] == m_stable[b]) all_diff = 1'b0;
        if (all_diff) m_stable[b] = ~m_stable[b];
      end
      for (int k = D; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = {bus.start_raw, bus.btn_raw};
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("movement", bus.movement, m_mov);
      check("queue_count", {2'b00, bus.queue_count}, 4'(m_q.size()));
      check("start_pulse", {3'b000, bus.start_pulse}, {3'b000, m_start});
    end
  end

  task automatic lit(input string name, input logic [3:0] exp_mov, input logic [3:0] exp_qc);
    check({name, "_mov"}, bus.movement, exp_mov);
    check({name, "_qc"}, {2'b00, bus.queue_count}, exp_qc);
    check({name, "_model_mov"}, m_mov, exp_mov);
    check({name, "_model_qc"}, 4'(m_q.size()), exp_qc);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] d);
    bus.btn_raw = d;
    cyc(D + 4);
    bus.btn_raw = '0;
    cyc(D + 4);
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    cyc(1);
    bus.tick = 1'b0;
  endtask

  task automatic flush();
    bus.game_active = 1'b0;
    cyc(1);
    lit("flush", 4'd0, 4'd0);
    bus.game_active = 1'b1;
  endtask

  initial begin
    int pulses;
    bus.btn_raw     = '0;
    bus.start_raw   = 1'b0;
    bus.tick        = 1'b0;
    bus.game_active = 1'b0;
    reset           = 1'b1;
    cyc(3);
    lit("reset", 4'd0, 4'd0);
    check("reset_start", {3'b000, bus.start_pulse}, 4'd0);
    reset           = 1'b0;
    bus.game_active = 1'b1;
    cyc(2);

    // Bounce then clean hold: turn appears exactly 2+D+1 edges into the hold.
    bus.btn_raw = 4'b1000; cyc(1);
    bus.btn_raw = 4'b0000; cyc(1);
    bus.btn_raw = 4'b1000; cyc(1);
    bus.btn_raw = 4'b0000; cyc(1);
    bus.btn_raw = 4'b1000;
    cyc(2 + D);
    lit("deb_before", 4'd0, 4'd0);
    cyc(1);
    lit("deb_after", 4'd0, 4'd1);
    bus.btn_raw = '0;
    cyc(D + 4);
    do_tick();
    lit("deb_tick", 4'b1000, 4'd0);

    // Queue depth two; third press dropped.
    press(4'b0001);
    press(4'b0100);
    press(4'b0010);
    lit("q_full", 4'b1000, 4'd2);
    do_tick(); lit("q_pop1", 4'b0001, 4'd1);
    do_tick(); lit("q_pop2", 4'b0100, 4'd0);
    do_tick(); lit("q_hold", 4'b0100, 4'd0);

    // Reverse presses against movement and against the queued tail.
    flush();
    press(4'b1000); do_tick(); lit("rev_setup", 4'b1000, 4'd0);
    press(4'b0100); lit("rev_lr", 4'b1000, FILT ? 4'd0 : 4'd1);
    flush();
    press(4'b1000); do_tick();
    press(4'b0001); lit("rev_up", 4'b1000, 4'd1);
    press(4'b0010); lit("rev_ud", 4'b1000, FILT ? 4'd1 : 4'd2);

    // Simultaneous presses and full-queue tick with a coincident push.
    flush();
    press(4'b1001); lit("prio", 4'd0, 4'd1);
    do_tick();      lit("prio_tick", 4'b0001, 4'd0);
    press(4'b0100);
    press(4'b0010); lit("sim_full", 4'b0001, 4'd2);
    bus.btn_raw = 4'b1000;
    cyc(2 + D);
    bus.tick = 1'b1;
    cyc(1);
    bus.tick = 1'b0;
    lit("sim_push_pop", 4'b0100, 4'd2);
    bus.btn_raw = '0;
    cyc(D + 4);
    do_tick(); lit("sim_tail1", 4'b0010, 4'd1);
    do_tick(); lit("sim_tail2", 4'b1000, 4'd0);

    // Start pulse while idle, then game_active drop with a full queue.
    bus.game_active = 1'b0;
    cyc(1);
    pulses = 0;
    bus.start_raw = 1'b1;
    for (int i = 0; i < 2 * D + 8; i++) begin
      if (i == D + 4) bus.start_raw = 1'b0;
      cyc(1);
      if (bus.start_pulse) pulses++;
    end
    check("start_pulses", 4'(pulses), 4'd1);
    bus.game_active = 1'b1;
    press(4'b0001);
    press(4'b0100);
    lit("ga_full", 4'd0, 4'd2);
    bus.game_active = 1'b0;
    cyc(1);
    lit("ga_drop", 4'd0, 4'd0);
    bus.game_active = 1'b1;

    // Asynchronous mid-cycle reset with a button held through release.
    press(4'b0001); do_tick();
    press(4'b0100); lit("pre_reset", 4'b0001, 4'd1);
    bus.btn_raw = 4'b0001;
    cyc(1);
    #2 reset = 1'b1;
    #1 lit("async_reset", 4'd0, 4'd0);
    check("async_reset_start", {3'b000, bus.start_pulse}, 4'd0);
    cyc(2);
    reset = 1'b0;
    cyc(2 + D);
    lit("rel_before", 4'd0, 4'd0);
    cyc(1);
    lit("rel_after", 4'd0, 4'd1);
    bus.btn_raw = '0;
    cyc(D + 4);

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) bus.btn_raw = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) bus.start_raw = ~bus.start_raw;
      bus.tick = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 149) == 0) bus.game_active = ~bus.game_active;
      if ($urandom_range(0, 799) == 0) begin
        #2 reset = 1'b1;
        cyc(1);
        reset = 1'b0;
      end else begin
        cyc(1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/snake_input_ctrl.md
Name: snake_input_ctrl

Overview:
Upstream conditioner for the snake `move` stage. It takes the four raw direction buttons and the raw start button, then synchronises, debounces and edge-detects them. Direction presses go into a 2-deep turn queue that is drained one entry per game step. The block drives the one-hot `movement` bus (UP=1, DOWN=2, LEFT=4, RIGHT=8) and a single-cycle `start_pulse`.

Parameters:
DEBOUNCE_CYCLES, 20000, consecutive clk samples a raw input must differ from its stable level before the stable level flips (must be ≥2)
CNT_W, 15, debounce counter width (must hold DEBOUNCE_CYCLES-1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
btn_raw  input  4  raw buttons, active-high; bit0=UP, bit1=DOWN, bit2=LEFT, bit3=RIGHT
start_raw  input  1  raw start button, active-high
tick  input  1  one-cycle game-step strobe, clk domain (parent derives it from the fout rising edge)
game_active  input  1  high while the snake is moving (not start/over screen)
movement  output  4  current one-hot direction; 0 = none
start_pulse  output  1  one-cycle pulse per debounced start press
queue_count  output  2  turn-queue occupancy, 0..2

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous and active-high. While reset is high, all state clears: sync flops, stable levels, counters, queue, movement=0, start_pulse=0, queue_count=0.
- Sync: each of the 5 raw inputs passes through a 2-flop synchroniser.
- Debounce (per input, independent counter):
  - If sync == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any glitch back to the stable level restarts the count.
- Press event: the registered rising edge of a stable level, one cycle wide. Release edges are ignored.
- Latency: press event is asserted 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after a clean raw rising edge.
- start_pulse = press event of start, registered; independent of game_active.
- Direction select: if several press events occur in one cycle, keep only the highest priority: UP > DOWN > LEFT > RIGHT. The others are discarded.
- Reference direction = last queue entry if queue_count>0, else movement. It is sampled before any same-cycle pop.
- Accept rule: a press is accepted only if it is not equal to the reference and (with the filter, see below) not its opposite.
- Push: an accepted press is pushed only if there is space after this cycle's pop. Otherwise it is dropped silently.
- Pop: on tick with queue_count>0, movement <= head entry and the queue shifts. On tick with an empty queue, movement holds.
- Simultaneous tick + push:
  - count 0: the new entry is pushed (not loaded to movement this tick).
  - count 1: pop and push, count stays 1.
  - count 2: pop and push, count stays 2.
- game_active low: queue flushed (count=0), movement <= 0, all pushes ignored. This matches the move stage clearing its direction on game over.
- game_active low-to-high: the queue is empty and movement=0. The first accepted press is applied at the next tick.
- Mid-operation reset: everything clears immediately; no pulse is generated when reset releases, even if buttons are held. A held button's stable level rises only after the full debounce interval.

Optional Feature:
REVERSE_FILTER_EN
- Defined: a press whose direction is the opposite of the reference (UP↔DOWN, LEFT↔RIGHT) is rejected and never queued.
- Not defined: opposite presses are accepted and queued (only duplicates rejected); the move stage performs its own reversal rejection.

Test Plan:
All tests use DEBOUNCE_CYCLES=4.
1. Reset: assert reset asynchronously mid-cycle while pressing btn_raw=4'b0001 → movement=0, queue_count=0, start_pulse=0 immediately; no press event after release until 4 stable samples.
2. Debounce: RIGHT bouncing 1,0,1,0 on single cycles, then held → exactly one push after the hold; glitches produce nothing; queue_count=1 at cycle 2+4+1 after hold start.
3. Queue: game_active=1; press UP, LEFT, DOWN before any tick → queue holds UP,LEFT (count=2), DOWN dropped. tick → movement=4'b0001; next tick → 4'b0100; third tick → holds 4'b0100.
4. Reverse, filter defined: movement=RIGHT, empty queue; press LEFT → rejected, count stays 0. Press UP then DOWN → UP queued, DOWN rejected. Filter undefined: both UP and DOWN queued.
5. Simultaneous: UP and RIGHT press events in the same cycle → only UP queued. Full queue + tick + new press in one cycle → movement=old head, count stays 2, new entry is at the tail.
6. game_active/start: start_raw pressed with game_active=0 → one start_pulse; drop game_active with count=2 → count=0, movement=0 next cycle.
